// File: rtl/pll_dps_pkg.sv
// Shared types and PHASESEL/PHASEDIR encodings for the ECP5 EHXPLLL dynamic phase stepper.
package pll_dps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_DONE,
    ST_ABORT
  } dps_state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// Issues timed PHASESEL/PHASEDIR/PHASESTEP sequences to an ECP5 EHXPLLL and aborts on lock loss.
import pll_dps_pkg::*;

module pll_phase_stepper #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 8,
  parameter int unsigned STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              busy,
  output logic              done,
  output logic              err_unlock,
  output logic [STEP_W-1:0] steps_done,
  output logic              locked_sync,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep
);

  localparam int unsigned MAX_CYC = max3(SETUP_CYC, PULSE_CYC, GAP_CYC);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  dps_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] count_q, count_d;
  logic [STEP_W-1:0] steps_done_q, steps_done_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              locked_s;
  logic              accept;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (locked_i),
    .q  (locked_s)
  );

  assign req_ready = (state_q == ST_IDLE) & locked_s & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    steps_done_d = steps_done_q;
    sel_d        = sel_q;
    dir_d        = dir_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_d        = req_sel;
          dir_d        = req_dir;
          count_d      = req_steps;
          steps_done_d = '0;
          if (req_steps == '0) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      ST_SETUP, ST_PULSE, ST_GAP: begin
        // Lock loss wins over every timed transition, so a pulse ending in
        // this cycle is dropped and never counted.
        if (!locked_s) begin
          state_d = ST_ABORT;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else if (state_q == ST_PULSE) begin
          state_d      = ST_GAP;
          cnt_d        = GAP_LD;
          steps_done_d = steps_done_q + 1'b1;
        end else if (steps_done_q < count_q) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE, ST_ABORT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with the state itself.
    step_d = (state_d == ST_PULSE);
    busy_d = (state_d == ST_SETUP) | (state_d == ST_PULSE) | (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      count_q      <= '0;
      steps_done_q <= '0;
      sel_q        <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      steps_done_q <= steps_done_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_unlock  = err_q;
  assign steps_done  = steps_done_q;
  assign locked_sync = locked_s;
  assign phasesel    = sel_q;
  assign phasedir    = dir_q;
  assign phasestep   = step_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed self-checking bench for pll_phase_stepper with per-cycle output traces.
module tb_pll_phase_stepper;
  import pll_dps_pkg::*;

  localparam int unsigned SETUP_CYC = 4;
  localparam int unsigned PULSE_CYC = 4;
  localparam int unsigned GAP_CYC   = 8;
  localparam int unsigned STEP_W    = 8;

  logic              clk;
  logic              rst;
  logic              locked_i;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;
  logic              busy;
  logic              done;
  logic              err_unlock;
  logic [STEP_W-1:0] steps_done;
  logic              locked_sync;
  logic [1:0]        phasesel;
  logic              phasedir;
  logic              phasestep;

  pll_phase_stepper #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .GAP_CYC  (GAP_CYC),
    .STEP_W   (STEP_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .locked_i   (locked_i),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_dir    (req_dir),
    .req_steps  (req_steps),
    .busy       (busy),
    .done       (done),
    .err_unlock (err_unlock),
    .steps_done (steps_done),
    .locked_sync(locked_sync),
    .phasesel   (phasesel),
    .phasedir   (phasedir),
    .phasestep  (phasestep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] rng(input int unsigned lo, input int unsigned hi);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Setup-stability and pulse-width monitor, sampled on the falling edge.
  logic        mon_en = 1'b0;
  logic        mon_step = 1'b0;
  logic [1:0]  mon_sel = '0;
  logic        mon_dir = 1'b0;
  int unsigned stable = 0;
  int unsigned hi_cnt = 0;

  always @(negedge clk) begin
    if (phasesel !== mon_sel || phasedir !== mon_dir) stable = 0;
    else stable++;
    if (phasestep === 1'b1 && mon_step !== 1'b1) begin
      hi_cnt = 1;
      if (mon_en) chk("setup_stable", 64'(stable >= SETUP_CYC), 64'(1));
    end else if (phasestep === 1'b1) begin
      hi_cnt++;
    end else if (mon_step === 1'b1 && mon_en) begin
      chk("pulse_width", 64'(hi_cnt), 64'(PULSE_CYC));
    end
    mon_step = phasestep;
    mon_sel  = phasesel;
    mon_dir  = phasedir;
  end

  logic [63:0] step_tr, done_tr, err_tr, busy_tr;

  task automatic wait_ready();
    int unsigned k;
    k = 0;
    while (req_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("ready_wait", 64'(req_ready), 64'(1));
  endtask

  // Returns positioned in cycle 1 (first cycle after the accept edge).
  task automatic issue(input logic [1:0] sel, input logic dir, input logic [STEP_W-1:0] steps,
                       input bit keep);
    wait_ready();
    req_sel   = sel;
    req_dir   = dir;
    req_steps = steps;
    req_valid = 1'b1;
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  // Records cycles 1..n; events fire at the end of the named cycle (0 = none).
  task automatic capture(input int unsigned n, input int unsigned drop_at,
                         input int unsigned rst_at, input int unsigned voff_at);
    step_tr = '0;
    done_tr = '0;
    err_tr  = '0;
    busy_tr = '0;
    for (int unsigned c = 1; c <= n; c++) begin
      step_tr[c] = phasestep;
      done_tr[c] = done;
      err_tr[c]  = err_unlock;
      busy_tr[c] = busy;
      if (c == drop_at) locked_i = 1'b0;
      if (c == rst_at) rst = 1'b1;
      if (rst_at != 0 && c == rst_at + 1) rst = 1'b0;
      if (c == voff_at) req_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    locked_i  = 1'b0;
    req_valid = 1'b0;
    req_sel   = '0;
    req_dir   = 1'b0;
    req_steps = '0;

    // Reset state, then lock arriving through the synchronizer
    tick();
    tick();
    chk("rst_flags", 64'({phasestep, busy, done, err_unlock, locked_sync, req_ready, phasedir}),
        64'(0));
    chk("rst_sel", 64'(phasesel), 64'(0));
    chk("rst_steps_done", 64'(steps_done), 64'(0));
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("unlocked_ready", 64'(req_ready), 64'(0));
    locked_i = 1'b1;
    tick();
    chk("lock_edge1_ready", 64'(req_ready), 64'(0));
    tick();
    chk("lock_edge2_ready", 64'(req_ready), 64'(1));

    // Two steps, CLKOP, lead
    mon_en = 1'b1;
    issue(SEL_CLKOP, DIR_LEAD, 8'd2, 1'b0);
    chk("t1_sel_c1", 64'(phasesel), 64'(SEL_CLKOP));
    chk("t1_dir_c1", 64'(phasedir), 64'(DIR_LEAD));
    chk("t1_steps_c1", 64'(steps_done), 64'(0));
    capture(32, 0, 0, 0);
    chk("t1_step_trace", step_tr, rng(5, 8) | rng(17, 20));
    chk("t1_done_trace", done_tr, rng(29, 29));
    chk("t1_busy_trace", busy_tr, rng(1, 28));
    chk("t1_err_trace", err_tr, 64'(0));
    chk("t1_steps_done", 64'(steps_done), 64'(2));
    chk("t1_sel_hold", 64'(phasesel), 64'(SEL_CLKOP));
    mon_en = 1'b0;

    // Zero steps
    issue(SEL_CLKOS, DIR_LAG, 8'd0, 1'b0);
    capture(8, 0, 0, 0);
    chk("t2_done_trace", done_tr, rng(1, 1));
    chk("t2_step_trace", step_tr, 64'(0));
    chk("t2_busy_trace", busy_tr, 64'(0));
    chk("t2_steps_done", 64'(steps_done), 64'(0));

    // Lock dropped in cycle 18: abort after the second pulse's last cycle, uncounted
    issue(SEL_CLKOS2, DIR_LAG, 8'd3, 1'b0);
    capture(24, 18, 0, 0);
    chk("t4_step_trace", step_tr, rng(5, 8) | rng(17, 20));
    chk("t4_err_trace", err_tr, rng(21, 21));
    chk("t4_done_trace", done_tr, 64'(0));
    chk("t4_busy_trace", busy_tr, rng(1, 20));
    chk("t4_steps_done", 64'(steps_done), 64'(1));
    chk("t4_ready_unlocked", 64'(req_ready), 64'(0));
    chk("t4_sel_hold", 64'(phasesel), 64'(SEL_CLKOS2));
    locked_i = 1'b1;
    tick();
    tick();
    chk("t4_relock_ready", 64'(req_ready), 64'(1));

    // Lock dropped in cycle 16: second pulse truncated to two cycles
    issue(SEL_CLKOS3, DIR_LEAD, 8'd3, 1'b0);
    capture(24, 16, 0, 0);
    chk("t4b_step_trace", step_tr, rng(5, 8) | rng(17, 18));
    chk("t4b_err_trace", err_tr, rng(19, 19));
    chk("t4b_done_trace", done_tr, 64'(0));
    chk("t4b_steps_done", 64'(steps_done), 64'(1));
    locked_i = 1'b1;

    // Reset in cycle 6 during the first pulse
    issue(SEL_CLKOP, DIR_LEAD, 8'd2, 1'b0);
    capture(12, 0, 6, 0);
    chk("t5_step_trace", step_tr, rng(5, 6));
    chk("t5_busy_trace", busy_tr, rng(1, 6));
    chk("t5_done_trace", done_tr, 64'(0));
    chk("t5_err_trace", err_tr, 64'(0));
    chk("t5_sel_cleared", 64'({phasesel, phasedir}), 64'(0));
    issue(SEL_CLKOS, DIR_LAG, 8'd1, 1'b0);
    capture(20, 0, 0, 0);
    chk("t5_after_step_trace", step_tr, rng(5, 8));
    chk("t5_after_done_trace", done_tr, rng(17, 17));
    chk("t5_after_steps_done", 64'(steps_done), 64'(1));

    // Back-to-back with req_valid held: second request accepted right after done
    mon_en = 1'b1;
    issue(SEL_CLKOS2, DIR_LAG, 8'd1, 1'b1);
    req_sel   = SEL_CLKOS3;
    req_dir   = DIR_LEAD;
    req_steps = 8'd2;
    capture(50, 0, 0, 19);
    chk("t6_step_trace", step_tr, rng(5, 8) | rng(23, 26) | rng(35, 38));
    chk("t6_done_trace", done_tr, rng(17, 17) | rng(47, 47));
    chk("t6_busy_trace", busy_tr, rng(1, 16) | rng(19, 46));
    chk("t6_steps_done", 64'(steps_done), 64'(2));
    chk("t6_sel_dir", 64'({phasesel, phasedir}), 64'({SEL_CLKOS3, DIR_LEAD}));
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
- Drives the dynamic phase-shift inputs of the ECP5 EHXPLLL: PHASESEL, PHASEDIR and PHASESTEP.
- Accepts a step request over a valid/ready handshake and emits correctly timed PHASESTEP pulses.
- Watches the PLL LOCK output and aborts on lock loss.
- Sits beside the PLL wrapper in the pixel/HDMI clock domain. Used to tune the camera-capture sampling phase at run time.

Parameters:
- SETUP_CYC, 4, cycles that PHASESEL/PHASEDIR are stable before the first PHASESTEP rise (>=1).
- PULSE_CYC, 4, PHASESTEP high width in cycles (>=1).
- GAP_CYC, 8, PHASESTEP low cycles after each pulse, before the next pulse or completion (>=1).
- STEP_W, 8, width of the step-count field.

Ports:
- clk  in  1  system clock (the PLL reference clock, not a PLL output).
- rst  in  1  synchronous, active-high reset.
- locked_i  in  1  PLL LOCK, asynchronous to clk.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_sel  in  2  output select: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP.
- req_dir  in  1  0 = delay (lag), 1 = advance (lead).
- req_steps  in  STEP_W  number of phase steps; 0 is legal.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse on normal completion.
- err_unlock  out  1  one-cycle pulse on abort due to lock loss.
- steps_done  out  STEP_W  pulses issued for the current or last request.
- locked_sync  out  1  synchronized lock.
- phasesel  out  2  to PLL PHASESEL[1:0].
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All outputs are registered.
- Values after an edge with rst=1:
  - phasesel=00, phasedir=0, phasestep=0.
  - busy=0, done=0, err_unlock=0, steps_done=0.
  - locked_sync=0, synchronizer flops=0.
  - State IDLE.
- Reset mid-operation: phasestep goes low on that edge; no done or err pulse is issued.
- locked_i passes through a 2-FF synchronizer, so locked_sync lags locked_i by 2 edges.
- req_ready = (state==IDLE) & locked_sync & ~rst.
- Accept occurs on an edge with req_valid & req_ready. On that edge:
  - phasesel, phasedir and the step count are latched.
  - steps_done is cleared and busy is set.
- phasesel and phasedir hold their values until the next accept, including after done or an abort.
- States:
  - IDLE: wait for accept. Go to SETUP, or to DONE if req_steps==0.
  - SETUP: SETUP_CYC cycles, phasestep=0, then PULSE.
  - PULSE: PULSE_CYC cycles, phasestep=1. On exit, steps_done increments, then GAP.
  - GAP: GAP_CYC cycles, phasestep=0. Then PULSE if steps_done < count, else DONE.
  - DONE: one cycle with done=1 and busy=0 (busy drops on entry to DONE), then IDLE.
  - ABORT: one cycle with err_unlock=1, busy=0, phasestep=0, then IDLE.
- Timing, counting cycle 1 as the first cycle after the accept edge:
  - Pulse k is high during cycles SETUP_CYC + (k-1)(PULSE_CYC+GAP_CYC) + 1 .. + PULSE_CYC.
  - done is high in cycle SETUP_CYC + N(PULSE_CYC+GAP_CYC) + 1.
  - For N=0, done is high in cycle 1.
- Lock loss: locked_sync=0 while in SETUP, PULSE or GAP causes ABORT on the next edge.
  - phasestep falls with that edge, even mid-pulse.
  - steps_done keeps only the fully completed pulses; a truncated pulse is not counted.
- Abort has priority over normal completion when both occur in the same cycle.
- req_valid is ignored while not ready. A request held valid while busy is accepted in the first ready cycle after IDLE is re-entered.
- steps_done never wraps, since the maximum count is 2^STEP_W-1.
- One internal down-counter, sized for max(SETUP_CYC, PULSE_CYC, GAP_CYC), is reloaded on every state entry.

Decomposition:
- Package pll_dps_pkg holds:
  - The state enum (IDLE, SETUP, PULSE, GAP, DONE, ABORT).
  - PHASESEL encoding constants: SEL_CLKOS=2'b00, SEL_CLKOS2=2'b01, SEL_CLKOS3=2'b10, SEL_CLKOP=2'b11.
  - DIR_LAG=0, DIR_LEAD=1.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with synchronous active-high reset. It is used for locked_i and is reusable elsewhere.

Test Plan:
- Defaults, locked_i=1 for 3+ cycles, request sel=11 dir=1 steps=2:
  - phasesel=11 and phasedir=1 from cycle 1.
  - phasestep high in cycles 5-8 and 17-20.
  - done high in cycle 29 only; steps_done=2.
- Request with steps=0 -> done in cycle 1, no phasestep activity, steps_done=0.
- locked_i=0 at reset release -> req_ready=0. Then locked_i=1 -> req_ready=1 exactly 2 edges later.
- steps=3, drop locked_i at cycle 18 (mid second pulse):
  - phasestep low within 3 edges.
  - err_unlock single pulse; done never asserts; steps_done=1.
  - Returns to IDLE; req_ready=0 until relock.
- rst=1 asserted in cycle 6 during a pulse:
  - The next edge clears phasestep, busy and phasesel.
  - No done or err pulse.
  - After release and lock, a new request works normally.
- Back-to-back: req_valid held high with two requests:
  - Second request accepted in the cycle after done.
  - Its SETUP spans SETUP_CYC full cycles.
  - Bench checks PHASESEL/PHASEDIR stability >= SETUP_CYC before every rise and pulse width == PULSE_CYC.
